// File: rtl/dcache_mem_stage.sv
// MEM-stage data access block: a small direct-mapped, write-through,
// no-write-allocate data cache in front of a word-wide req/ack memory.
// Loads that hit return data combinationally. Misses and all stores stall the
// pipeline until the external transaction completes, then present one
// un-stalled completion cycle.
module dcache_mem_stage #(
    parameter int unsigned LINES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRdWait = 2'd1;
    localparam logic [1:0] StWrWait = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]       state_q, state_d;

    // Per-line storage; only the valid bits are reset.
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Registered bus request, plus the completion data shown in DONE.
    logic             mem_req_q, mem_we_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;
    logic [31:0]      cpl_data_q;
    logic             cpl_rd_q;

    logic [31:0]      addr_aligned;
    logic [IDX_W-1:0] req_idx, bus_idx;
    logic [TAG_W-1:0] req_tag, bus_tag;
    logic             req_hit, bus_hit;
    logic             start_rd, start_wr;
    logic             rd_ack, wr_ack;
    logic [31:0]      rdata;
    logic             stall;

    // Low address bits are masked rather than sliced away: unaligned accesses are word accesses.
    assign addr_aligned = addr_i & 32'hFFFF_FFFC;

    assign req_idx = addr_i[IDX_W+1:2];
    assign req_tag = addr_i[31:IDX_W+2];
    // Fill and write-through use the latched bus address, not the live pipeline input.
    assign bus_idx = mem_addr_q[IDX_W+1:2];
    assign bus_tag = mem_addr_q[31:IDX_W+2];

    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign bus_hit = valid_q[bus_idx] && (tag_q[bus_idx] == bus_tag);

    assign rd_ack = (state_q == StRdWait) && mem_ack_i;
    assign wr_ack = (state_q == StWrWait) && mem_ack_i;

    // Next-state, stall and load-data decode.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        rdata    = '0;
        start_rd = 1'b0;
        start_wr = 1'b0;
        case (state_q)
            StIdle: begin
                if (MemWrite_i) begin
                    stall    = 1'b1;
                    start_wr = 1'b1;
                    state_d  = StWrWait;
                end else if (MemRead_i) begin
                    if (req_hit) begin
                        rdata = data_q[req_idx];
                    end else begin
                        stall    = 1'b1;
                        start_rd = 1'b1;
                        state_d  = StRdWait;
                    end
                end
            end
            StRdWait, StWrWait: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Inputs still belong to the completing instruction; do not re-decode them.
                rdata   = cpl_rd_q ? cpl_data_q : 32'h0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM, valid bits, bus request registers and completion data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpl_data_q  <= '0;
            cpl_rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_rd || start_wr) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= start_wr;
                mem_addr_q  <= addr_aligned;
                mem_wdata_q <= wdata_i;
            end else if (rd_ack || wr_ack) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end
            if (rd_ack) begin
                valid_q[bus_idx] <= 1'b1;
                cpl_data_q       <= mem_rdata_i;
                cpl_rd_q         <= 1'b1;
            end else if (wr_ack) begin
                cpl_rd_q <= 1'b0;
            end
        end
    end

    // Tag/data arrays: refill on read ack, write-through update only on a store hit.
    always_ff @(posedge clk_i) begin
        if (rd_ack) begin
            tag_q[bus_idx]  <= bus_tag;
            data_q[bus_idx] <= mem_rdata_i;
        end else if (wr_ack && bus_hit) begin
            data_q[bus_idx] <= mem_wdata_q;
        end
    end

    assign rdata_o     = rdata;
    assign stall_o     = stall;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
